// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline controller: Stop/NoStop levels,
// per-requester stall encodings, the exception vector and FSM state encoding.
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    // Stall vectors are always a contiguous run of ones from bit0: the first
    // stage with a 0 bit behind a held stage receives a bubble.
    localparam logic [5:0] STALL_NONE = {6{NOSTOP}};
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PEND    = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_REFETCH = 2'd3
    } state_e;

    // Priority stall encoder: the most downstream requester wins.
    function automatic logic [5:0] stall_encode(
        input logic req_if,
        input logic req_id,
        input logic req_ex,
        input logic req_mem
    );
        if (req_mem == STOP)     return STALL_MEM;
        else if (req_ex == STOP) return STALL_EX;
        else if (req_id == STOP) return STALL_ID;
        else if (req_if == STOP) return STALL_IF;
        else                     return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// ---------------------------------------------------------------------------
// stall_watchdog
// Counts consecutive stalled cycles with a 16-bit saturating counter and
// raises a sticky timeout flag once the count reaches 16'hFFFF.
//   clk         : clock
//   reset       : synchronous active-high reset
//   i_stall_any : some stage is held this cycle
//   i_flush     : pipeline flush this cycle (clears the count)
//   o_timeout   : sticky flag, cleared only by reset
// ---------------------------------------------------------------------------
module stall_watchdog (
    input  logic clk,
    input  logic reset,
    input  logic i_stall_any,
    input  logic i_flush,
    output logic o_timeout
);

    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic        r_timeout;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (!i_stall_any || i_flush)
            w_cnt_nxt = 16'h0000;
        else if (r_cnt != 16'hFFFF)
            w_cnt_nxt = r_cnt + 16'h0001;
    end

    // The flag is set from the next count so it rises on the same edge the
    // counter reaches 16'hFFFF.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= 16'h0000;
            r_timeout <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == 16'hFFFF)
                r_timeout <= 1'b1;
        end
    end

    assign o_timeout = r_timeout;

endmodule

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
// Pipeline hazard/redirect controller: combinational stall encoder plus a
// RUN/PEND/FLUSH/REFETCH FSM that turns a committed exception or ERET into a
// one-cycle flush and a PC redirect, and a stall watchdog.
//   clk, reset        : clock, synchronous active-high reset
//   stallreq_if/id/ex/mem : per-stage stall requests
//   except_valid, eret: redirect requests from MEM (exception wins)
//   epc               : ERET target
//   stall[5:0]        : per-stage hold vector (bit0 PC .. bit5 WB)
//   flush             : one-cycle clear of all pipeline registers
//   new_pc, new_pc_valid : redirect target and PC load enable
//   stall_timeout     : sticky watchdog flag
// ---------------------------------------------------------------------------
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        except_valid,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        new_pc_valid,
    output logic        stall_timeout
);

    state_e      r_state;
    state_e      w_state_nxt;
    logic [31:0] r_target;
    logic        w_redirect_req;
    logic [31:0] w_target_sel;
    logic [5:0]  w_stall;
    logic        w_flush;
    logic        w_pc_valid;

    assign w_redirect_req = except_valid | eret;
    assign w_target_sel   = except_valid ? EXC_VECTOR : epc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_RUN;
            r_target <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            // Target is captured only from RUN; PEND ignores new requests.
            if (r_state == ST_RUN && w_redirect_req)
                r_target <= w_target_sel;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stall     = STALL_NONE;
        w_flush     = 1'b0;
        w_pc_valid  = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_stall = stall_encode(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
                if (w_redirect_req)
                    w_state_nxt = stallreq_mem ? ST_PEND : ST_FLUSH;
            end
            ST_PEND: begin
                w_stall = STALL_MEM;
                if (!stallreq_mem)
                    w_state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                w_flush     = 1'b1;
                w_pc_valid  = 1'b1;
                w_state_nxt = stallreq_if ? ST_REFETCH : ST_RUN;
            end
            ST_REFETCH: begin
                w_stall    = STALL_IF;
                w_pc_valid = 1'b1;
                if (!stallreq_if)
                    w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // Reset masks outputs in the reset cycle itself, whatever state was held.
    assign stall        = reset ? STALL_NONE : w_stall;
    assign flush        = reset ? 1'b0 : w_flush;
    assign new_pc_valid = reset ? 1'b0 : w_pc_valid;
    assign new_pc       = reset ? 32'h0 : r_target;

    stall_watchdog u_wdog (
        .clk         (clk),
        .reset       (reset),
        .i_stall_any (|stall),
        .i_flush     (flush),
        .o_timeout   (stall_timeout)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic        except_valid, eret;
    logic [31:0] epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        new_pc_valid;
    logic        stall_timeout;

    int errors = 0;
    int checks = 0;

    pipe_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .except_valid (except_valid),
        .eret         (eret),
        .epc          (epc),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .new_pc_valid (new_pc_valid),
        .stall_timeout(stall_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change just after the edge, checks 1 later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
        except_valid = 0; eret = 0;
    endtask

    // {if,id,ex,mem} -> expected stall in RUN
    logic [3:0] enc_req [8] = '{4'b0000, 4'b1000, 4'b0100, 4'b0010,
                                4'b0001, 4'b1111, 4'b1110, 4'b1100};
    logic [5:0] enc_exp [8] = '{6'b000000, 6'b000011, 6'b000111, 6'b001111,
                                6'b011111, 6'b011111, 6'b001111, 6'b000111};

    initial begin
        // Reset cycle with noisy inputs: outputs must all be quiet.
        reset = 1; epc = 32'hDEAD_BEEF;
        stallreq_if = 1; stallreq_id = 1; stallreq_ex = 1; stallreq_mem = 1;
        except_valid = 1; eret = 1;
        #1;
        chk("rst_stall", {26'd0, stall}, 32'h0);
        chk("rst_flush", {31'd0, flush}, 32'h0);
        chk("rst_newpc", new_pc, 32'h0);
        chk("rst_pcv", {31'd0, new_pc_valid}, 32'h0);
        chk("rst_tmo", {31'd0, stall_timeout}, 32'h0);
        tick();
        tick();
        reset = 0; clr_in(); #1;
        chk("run_newpc0", new_pc, 32'h0);

        // Stall encoder table
        for (int i = 0; i < 8; i++) begin
            {stallreq_if, stallreq_id, stallreq_ex, stallreq_mem} = enc_req[i];
            #1;
            chk($sformatf("enc%0d", i), {26'd0, stall}, {26'd0, enc_exp[i]});
            tick();
        end
        clr_in(); tick();

        // ex+id for 3 cycles
        stallreq_ex = 1; stallreq_id = 1;
        for (int i = 0; i < 3; i++) begin
            #1; chk($sformatf("exid%0d", i), {26'd0, stall}, 32'h0000_000F);
            tick();
        end
        clr_in(); #1;
        chk("exid_done", {26'd0, stall}, 32'h0);
        tick();

        // Exception, no mem stall: flush exactly one cycle later
        except_valid = 1; #1;
        chk("exc_n_flush", {31'd0, flush}, 32'h0);
        tick(); clr_in(); #1;
        chk("exc_n1_flush", {31'd0, flush}, 32'h1);
        chk("exc_n1_pc", new_pc, 32'hBFC0_0380);
        chk("exc_n1_pcv", {31'd0, new_pc_valid}, 32'h1);
        chk("exc_n1_stall", {26'd0, stall}, 32'h0);
        tick();
        chk("exc_n2_flush", {31'd0, flush}, 32'h0);
        chk("exc_n2_pcv", {31'd0, new_pc_valid}, 32'h0);
        chk("exc_n2_hold", new_pc, 32'hBFC0_0380);

        // ERET under mem stall for 4 cycles -> PEND, later exception ignored
        eret = 1; epc = 32'h8000_1234; stallreq_mem = 1; #1;
        chk("eret_c0_stall", {26'd0, stall}, 32'h1F);
        tick(); eret = 0;
        for (int i = 1; i < 4; i++) begin
            if (i == 2) except_valid = 1;
            #1;
            chk($sformatf("eret_c%0d_stall", i), {26'd0, stall}, 32'h1F);
            chk($sformatf("eret_c%0d_flush", i), {31'd0, flush}, 32'h0);
            tick(); except_valid = 0;
        end
        stallreq_mem = 0; #1;
        chk("pend_exit_flush", {31'd0, flush}, 32'h0);
        tick();
        chk("eret_flush", {31'd0, flush}, 32'h1);
        chk("eret_pc", new_pc, 32'h8000_1234);
        chk("eret_pcv", {31'd0, new_pc_valid}, 32'h1);
        tick();
        chk("eret_after", {31'd0, flush}, 32'h0);

        // Exception and ERET together: exception vector wins
        except_valid = 1; eret = 1; epc = 32'h1111_2222;
        tick(); clr_in(); #1;
        chk("both_flush", {31'd0, flush}, 32'h1);
        chk("both_pc", new_pc, 32'hBFC0_0380);
        tick();

        // Flush with stallreq_if held 5 cycles -> 5 REFETCH cycles
        eret = 1; epc = 32'h1000_0040;
        tick(); clr_in(); stallreq_if = 1; #1;
        chk("rf_flush", {31'd0, flush}, 32'h1);
        chk("rf_flush_pc", new_pc, 32'h1000_0040);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 4) stallreq_if = 0;
            #1;
            chk($sformatf("rf%0d_stall", i), {26'd0, stall}, 32'h03);
            chk($sformatf("rf%0d_pcv", i), {31'd0, new_pc_valid}, 32'h1);
            chk($sformatf("rf%0d_flush", i), {31'd0, flush}, 32'h0);
        end
        tick();
        chk("rf_run_stall", {26'd0, stall}, 32'h0);
        chk("rf_run_pcv", {31'd0, new_pc_valid}, 32'h0);

        // Reset while in PEND discards the redirect
        eret = 1; epc = 32'h2222_0000; stallreq_mem = 1;
        tick(); eret = 0; tick();
        reset = 1; #1;
        chk("pend_rst_stall", {26'd0, stall}, 32'h0);
        chk("pend_rst_pc", new_pc, 32'h0);
        tick(); reset = 0; clr_in();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("post_rst%0d_flush", i), {31'd0, flush}, 32'h0);
            chk($sformatf("post_rst%0d_pcv", i), {31'd0, new_pc_valid}, 32'h0);
            tick();
        end
        chk("post_rst_pc", new_pc, 32'h0);

        // Watchdog: 65535 stalled edges bring the counter to FFFF
        stallreq_mem = 1;
        for (int i = 0; i < 65534; i++) tick();
        chk("wd_pre", {31'd0, stall_timeout}, 32'h0);
        tick();
        chk("wd_set", {31'd0, stall_timeout}, 32'h1);
        stallreq_mem = 0;
        tick(); tick(); tick();
        chk("wd_sticky", {31'd0, stall_timeout}, 32'h1);
        reset = 1; tick(); reset = 0; #1;
        chk("wd_rst", {31'd0, stall_timeout}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have: clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have: stallreq_if  in  1  fetch busy (icache miss or outstanding fetch).
REQ-004 SHALL have: stallreq_id  in  1  load-use hazard detected in decode.
REQ-005 SHALL have: stallreq_ex  in  1  multi-cycle EX operation busy (mul/div).
REQ-006 SHALL have: stallreq_mem  in  1  data access busy.
REQ-007 SHALL have: except_valid  in  1  committed exception reported by MEM stage.
REQ-008 SHALL have: eret  in  1  ERET committing in MEM stage.
REQ-009 SHALL have: epc  in  32  CP0 EPC value, used as the ERET target.
REQ-010 SHALL have: stall  out  6  per-stage hold vector: bit0 PC, bit1 IF/ID, bit2 ID/EXE, bit3 EXE/MEM, bit4 MEM/WB, bit5 WB; 1 = Stop.
REQ-011 SHALL have: flush  out  1  one-cycle clear of all pipeline registers.
REQ-012 SHALL have: new_pc  out  32  redirect target.
REQ-013 SHALL have: new_pc_valid  out  1  PC register SHALL load new_pc while high.
REQ-014 SHALL have: stall_timeout  out  1  sticky watchdog flag.

Function
REQ-015 SHALL use constant EXC_VECTOR = 32'hBFC0_0380.
REQ-016 SHALL be a four-state FSM (RUN, PEND, FLUSH, REFETCH) with registered state.
REQ-017 In RUN, the stall encoding SHALL be combinational, with highest requester winning: mem 6'b011111, ex 6'b001111, id 6'b000111, if 6'b000011, none 6'b000000.
REQ-018 The stall vector SHALL always be a contiguous run of ones from bit0, so the boundary stage (e.g. ID/EXE with bit2=1, bit3=0) inserts a bubble.
REQ-019 In RUN, when (except_valid or eret) and stallreq_mem=0, the block SHALL go to FLUSH the next cycle and latch the target: EXC_VECTOR if except_valid, else epc.
REQ-020 When except_valid and eret are high together, except_valid SHALL win.
REQ-021 In RUN, when (except_valid or eret) and stallreq_mem=1, the block SHALL latch the target, go to PEND, and hold stall=6'b011111.
REQ-022 PEND SHALL ignore further except_valid/eret, hold stall=6'b011111, and go to FLUSH in the first cycle stallreq_mem=0.
REQ-023 FLUSH SHALL last exactly one cycle with flush=1, new_pc_valid=1, stall=6'b000000.
REQ-024 FLUSH SHALL exit to REFETCH if stallreq_if=1 in that cycle, else to RUN.
REQ-025 REFETCH SHALL hold stall=6'b000011, new_pc_valid=1 and new_pc at the latched target, with flush=0, until stallreq_if=0, then go to RUN.
REQ-026 Latency from except_valid sampled with no mem stall to the flush pulse SHALL be exactly one cycle.
REQ-027 Outside FLUSH/REFETCH, new_pc_valid SHALL be 0 and new_pc SHALL hold its last latched value.
REQ-028 A 16-bit saturating counter SHALL increment on each cycle with stall!=0 and clear on a cycle with stall==0 or flush=1.
REQ-029 stall_timeout SHALL set when the counter reaches 16'hFFFF and clear only on reset.

Reset
REQ-030 Reset SHALL force state=RUN, the latched target to 32'h0, the counter to 0, and stall_timeout=0.
REQ-031 In the reset cycle, stall=6'b000000, flush=0, new_pc=32'h0 and new_pc_valid=0, regardless of inputs.
REQ-032 Reset in PEND/FLUSH/REFETCH SHALL discard the pending redirect; no flush is emitted after reset.

Structure
REQ-033 The stall encodings, Stop/NoStop, EXC_VECTOR and state encodings SHALL live in the shared global define file.
REQ-034 The FSM and stall encoder SHALL be one module; the watchdog SHALL be sub-module stall_watchdog.

Verification
REQ-035 stallreq_ex=1 and stallreq_id=1 for 3 cycles -> stall=6'b001111 for those 3 cycles, then 6'b000000.
REQ-036 except_valid=1 with stallreq_mem=0 at cycle N -> cycle N+1: flush=1, new_pc=32'hBFC00380, new_pc_valid=1; cycle N+2: flush=0.
REQ-037 eret=1 with epc=32'h8000_1234 and stallreq_mem=1 for 4 cycles -> stall=6'b011111 throughout, then one flush with new_pc=32'h80001234.
REQ-038 except_valid=1 and eret=1 together -> new_pc=32'hBFC00380.
REQ-039 Flush with stallreq_if held 5 cycles -> REFETCH: stall=6'b000011 and new_pc_valid=1 for 5 cycles, then RUN.
REQ-040 Reset asserted in PEND -> no flush afterwards; stallreq_mem held 65535 cycles -> stall_timeout=1, sticky until reset.
